// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader.
package instruction_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int CNT_W          = 8 * HDR_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } loader_state_t;

  // A word count is usable only if it is non-zero and fits the memory.
  function automatic logic count_in_range(input logic [CNT_W-1:0] n, input int depth);
    return (n != '0) && (int'(n) <= depth);
  endfunction

  // States during which the CPU must be held off the instruction memory.
  function automatic logic is_busy(input loader_state_t s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA) ||
           (s == ST_WRITE)  || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte stream in, instruction-memory write port out.
// Handshake: a byte moves on a rising clk edge where byte_valid and byte_ready
// are both high; the source holds byte_data stable while byte_valid is high and
// byte_ready is low, and byte_ready never depends combinationally on byte_valid.
interface instruction_loader_if #(
  parameter int ADDR_W = 5
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Host/memory side: drives the byte stream, observes the write port.
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side: consumes the byte stream, drives the write port.
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Big-endian 4-byte shift register with byte index and running XOR checksum.
module instruction_loader_word_assembler
  import instruction_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o,
  output logic [BYTE_W-1:0] csum_o
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  // Next values: clear wins over shift; each shift pushes the byte in at the LSB end.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    csum_d = csum_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
      csum_d = '0;
    end else if (shift_i) begin
      idx_d  = idx_q + 2'd1;
      word_d = {word_q[WORD_W-BYTE_W-1:0], byte_i};
      csum_d = csum_q ^ byte_i;
    end
  end

  // Register the assembler state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
      csum_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  // Flags the shift that completes a word (the index wraps back to 0 on it).
  assign word_full_o = shift_i && !clear_i && (idx_q == 2'(BYTES_PER_WORD - 1));
  assign word_o      = word_q;
  assign csum_o      = csum_q;

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  instruction_loader_if.slave  bus,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error,
  output loader_state_t        dbg_state_o
);

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] word_cnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;
  logic              cpu_hold_q, done_q, error_q;

  logic              byte_ready_s, start_s, shift_s, write_s, xfer_s, last_word_s;
  logic [WORD_W-1:0] asm_word;
  logic              asm_full;
  logic [BYTE_W-1:0] asm_csum;

  assign xfer_s      = bus.byte_valid & byte_ready_s;
  assign last_word_s = (16'(word_cnt_q) == (count_q - 16'd1));

  instruction_loader_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (start_s),
    .shift_i     (shift_s),
    .byte_i      (bus.byte_data),
    .word_o      (asm_word),
    .word_full_o (asm_full),
    .csum_o      (asm_csum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (load_start) state_d = ST_HDR_HI;
      ST_HDR_HI: if (xfer_s) state_d = ST_HDR_LO;
      ST_HDR_LO: begin
        if (xfer_s) begin
          state_d = count_in_range({count_q[15:8], bus.byte_data}, DEPTH) ? ST_DATA : ST_ERR;
        end
      end
      ST_DATA:  if (asm_full) state_d = ST_WRITE;
      ST_WRITE: state_d = last_word_s ? ST_CSUM : ST_DATA;
      ST_CSUM: begin
        if (xfer_s) state_d = (bus.byte_data == asm_csum) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-state strobes: byte acceptance, load start, data shift, memory write.
  always_comb begin
    byte_ready_s = 1'b0;
    start_s      = 1'b0;
    shift_s      = 1'b0;
    write_s      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: start_s = load_start;
      ST_HDR_HI, ST_HDR_LO, ST_CSUM: byte_ready_s = 1'b1;
      ST_DATA: begin
        byte_ready_s = 1'b1;
        shift_s      = bus.byte_valid;
      end
      ST_WRITE: write_s = 1'b1;
      default: ;
    endcase
  end

  // Counters, write port registers and status levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      word_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      if (start_s) begin
        count_q    <= '0;
        word_cnt_q <= '0;
      end else begin
        if (xfer_s && (state_q == ST_HDR_HI)) count_q[15:8] <= bus.byte_data;
        if (xfer_s && (state_q == ST_HDR_LO)) count_q[7:0]  <= bus.byte_data;
        // The last word leaves the counter at N-1 so it never passes DEPTH-1.
        if (write_s && !last_word_s) word_cnt_q <= word_cnt_q + 1'b1;
      end
      // Write port is loaded on the completing byte so it is valid in WRITE and held after.
      mem_we_q <= asm_full;
      if (asm_full) begin
        mem_addr_q  <= word_cnt_q;
        mem_wdata_q <= {asm_word[WORD_W-BYTE_W-1:0], bus.byte_data};
      end
      cpu_hold_q <= is_busy(state_d);
      done_q     <= (state_d == ST_DONE);
      error_q    <= (state_d == ST_ERR);
    end
  end

  assign bus.byte_ready = byte_ready_s;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign error          = error_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;
  import instruction_loader_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0;
  logic cpu_hold, done, error;
  loader_state_t dbg_state;

  always #5 clk = ~clk;

  instruction_loader_if #(.ADDR_W(ADDR_W)) lif ();

  instruction_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .bus         (lif.slave),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [ADDR_W+31:0] exp_q[$];     // expected {addr, data} writes
  logic [1:0]         exp_st_q[$];  // expected {done, error} at end of load
  logic [31:0]        prog[$];      // words of the program being sent
  logic               prev_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (lif.mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {lif.mem_addr, lif.mem_wdata}, 64'hDEAD);
        end else begin
          check("write", {lif.mem_addr, lif.mem_wdata}, exp_q.pop_front());
        end
        check("ready_low_in_write", lif.byte_ready, 1'b0);
      end
      if (prev_hold && !cpu_hold) begin
        if (exp_st_q.size() == 0) check("unexpected_end", {done, error}, 2'b11);
        else check("end_status", {done, error}, exp_st_q.pop_front());
      end
      prev_hold = cpu_hold;
    end
  end

  // ---------------- drivers ----------------
  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
    check("start_hold", cpu_hold, 1'b1);
    check("start_clears_status", {done, error}, 2'b00);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    lif.byte_valid = 1'b1;
    lif.byte_data  = b;
    load_start     = poke;
    while (!lif.byte_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("byte_accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    lif.byte_valid = 1'b0;
    load_start     = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (cpu_hold && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) check("idle_timeout", 1'b0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  // Reference model + driver for one load: n is the header count, prog holds the words.
  task automatic run_load(input int n, input bit bad_csum, input int max_gap,
                          input int abort_after, input int poke_at);
    logic [15:0] n16;
    logic [7:0]  csum, b;
    logic [31:0] w;
    bit          ok_hdr;
    int          k;
    n16    = 16'(n);
    ok_hdr = (n >= 1) && (n <= DEPTH);
    csum   = 8'h00;
    foreach (prog[i]) csum = csum ^ prog[i][31:24] ^ prog[i][23:16] ^ prog[i][15:8] ^ prog[i][7:0];
    if (ok_hdr) begin
      for (int i = 0; i < n; i++) begin
        if (abort_after < 0 || (i + 1) * 4 <= abort_after)
          exp_q.push_back({ADDR_W'(i), prog[i]});
      end
    end
    if (abort_after < 0) begin
      if (!ok_hdr)       exp_st_q.push_back(2'b01);
      else if (bad_csum) exp_st_q.push_back(2'b01);
      else               exp_st_q.push_back(2'b10);
    end

    start_load();
    send_byte(n16[15:8], $urandom_range(0, max_gap), 1'b0);
    send_byte(n16[7:0],  $urandom_range(0, max_gap), 1'b0);
    if (ok_hdr) begin
      k = 0;
      for (int i = 0; i < n; i++) begin
        w = prog[i];
        for (int j = 0; j < 4; j++) begin
          b = w[31:24];
          w = w << 8;
          send_byte(b, $urandom_range(0, max_gap), (k == poke_at));
          k++;
          if (k == abort_after) begin
            #2 rst_n = 1'b0;
            #1;
            check("async_reset_outputs",
                  {cpu_hold, done, error, lif.mem_we, lif.byte_ready, lif.mem_addr, lif.mem_wdata},
                  '0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            return;
          end
        end
      end
      send_byte(bad_csum ? (csum ^ 8'h01) : csum, $urandom_range(0, max_gap), 1'b0);
    end
    wait_idle();
  endtask

  task automatic fill_random(input int nwords);
    prog.delete();
    for (int i = 0; i < nwords; i++) prog.push_back($urandom);
  endtask

  task automatic fill_nominal();
    prog.delete();
    prog.push_back(32'h20080005);
    prog.push_back(32'h01095020);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    lif.byte_valid = 1'b0;
    lif.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {cpu_hold, done, error, lif.mem_we, lif.byte_ready, lif.mem_addr, lif.mem_wdata}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready_low", lif.byte_ready, 1'b0);

    // Nominal two-word program, streamed back to back.
    fill_nominal();
    run_load(2, 1'b0, 0, -1, -1);
    check("done_level_held", {done, error, cpu_hold}, 3'b100);

    // Same program with stalls between bytes.
    fill_nominal();
    run_load(2, 1'b0, 3, -1, -1);

    // Header errors: zero count and count above DEPTH.
    prog.delete();
    run_load(0, 1'b0, 1, -1, -1);
    check("hdr0_error_level", {done, error, cpu_hold}, 3'b010);
    run_load(33, 1'b0, 1, -1, -1);

    // Bad checksum after both writes.
    fill_nominal();
    run_load(2, 1'b1, 0, -1, -1);
    check("csum_error_level", {done, error}, 2'b01);

    // Reset after six data bytes, then a clean reload.
    fill_nominal();
    run_load(2, 1'b0, 0, 6, -1);
    repeat (2) @(negedge clk);
    check("post_reset_idle", {cpu_hold, done, error}, 3'b000);
    fill_nominal();
    run_load(2, 1'b0, 1, -1, -1);

    // Full-depth load with a load_start poked mid-data.
    fill_random(DEPTH);
    run_load(DEPTH, 1'b0, 1, -1, 10);

    // Fresh loads started straight out of DONE/ERR, random sizes and checksums.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, DEPTH + 2);
      fill_random((n >= 1 && n <= DEPTH) ? n : 0);
      run_load(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), -1, -1);
    end

    check("writes_drained", 64'(exp_q.size()), 64'd0);
    check("status_drained", 64'(exp_st_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
